// File: rtl/bg_fade_pkg.sv
// Shared types and constants for the background brightness fader.
package bg_fade_pkg;

   localparam int BRIGHT_W = 5;
   localparam int COLOR_W  = 4;
   localparam logic [BRIGHT_W-1:0] BRIGHT_FULL = 5'd16;

   typedef enum logic [1:0] {
      IDLE,
      FADE_OUT,
      FADE_IN,
      FLASH
   } fade_state_t;

   typedef enum logic [1:0] {
      OP_FADE_OUT  = 2'd0,
      OP_FADE_IN   = 2'd1,
      OP_FLASH     = 2'd2,
      OP_SNAP_FULL = 2'd3
   } fade_op_t;

endpackage

// File: rtl/bg_color_scale.sv
// One colour channel scaled by brightness/16; 16 leaves the colour unchanged.
module bg_color_scale
   import bg_fade_pkg::*;
(
   input  logic [COLOR_W-1:0]  color,
   input  logic [BRIGHT_W-1:0] bright,
   output logic [COLOR_W-1:0]  scaled
);

   always_comb begin
      scaled = COLOR_W'((8'(color) * 8'(bright)) >> 4);
   end

endmodule

// File: rtl/background_fade_ctrl.sv
// Frame-synchronous brightness sequencer (fade out/in, flash, snap) feeding
// a one-stage registered RGB scaling path.
module background_fade_ctrl
   import bg_fade_pkg::*;
#(
   parameter int FRAMES_PER_STEP = 4,
   parameter int FLASH_TOGGLES   = 8,
   parameter int FLASH_DIM       = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                frame_start,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_op,
   input  logic                pix_valid_in,
   input  logic [COLOR_W-1:0]  red_in,
   input  logic [COLOR_W-1:0]  green_in,
   input  logic [COLOR_W-1:0]  blue_in,
   output logic                pix_valid_out,
   output logic [COLOR_W-1:0]  red_out,
   output logic [COLOR_W-1:0]  green_out,
   output logic [COLOR_W-1:0]  blue_out,
   output logic [BRIGHT_W-1:0] brightness,
   output logic                busy,
   output logic                done
);

   localparam int FCW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam int TCW = $clog2(FLASH_TOGGLES + 1);
   localparam logic [FCW-1:0]      FRAME_LAST = FCW'(FRAMES_PER_STEP - 1);
   localparam logic [TCW-1:0]      TOG_LAST   = TCW'(FLASH_TOGGLES - 1);
   localparam logic [BRIGHT_W-1:0] DIM        = BRIGHT_W'(FLASH_DIM);

   fade_state_t         state_q, state_d;
   logic [BRIGHT_W-1:0] bright_q, bright_d;
   logic [FCW-1:0]      frame_q, frame_d;
   logic [TCW-1:0]      tog_q, tog_d;
   logic                done_d, step_tick;
   fade_op_t            op;
   logic [COLOR_W-1:0]  red_s, green_s, blue_s;

   assign op         = fade_op_t'(cmd_op);
   assign cmd_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign brightness = bright_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         bright_q <= BRIGHT_FULL;
         frame_q  <= '0;
         tog_q    <= '0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         bright_q <= bright_d;
         frame_q  <= frame_d;
         tog_q    <= tog_d;
         done     <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bright_d  = bright_q;
      frame_d   = frame_q;
      tog_d     = tog_q;
      done_d    = 1'b0;
      step_tick = 1'b0;

      // Frames only count once a command is running, so a frame_start
      // coinciding with acceptance is never part of the first step.
      if (state_q != IDLE && frame_start) begin
         if (frame_q == FRAME_LAST) begin
            frame_d   = '0;
            step_tick = 1'b1;
         end else begin
            frame_d = frame_q + 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               frame_d = '0;
               tog_d   = '0;
               case (op)
                  OP_FADE_OUT: state_d = FADE_OUT;
                  OP_FADE_IN:  state_d = FADE_IN;
                  OP_FLASH: begin
                     state_d  = FLASH;
                     bright_d = BRIGHT_FULL;
                  end
                  default: begin
                     bright_d = BRIGHT_FULL;
                     done_d   = 1'b1;
                  end
               endcase
            end
         end
         FADE_OUT: begin
            if (step_tick) begin
               if (bright_q != '0) bright_d = bright_q - 1'b1;
               if (bright_q <= 5'd1) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         FADE_IN: begin
            if (step_tick) begin
               if (bright_q < BRIGHT_FULL) bright_d = bright_q + 1'b1;
               if (bright_q >= BRIGHT_FULL - 5'd1) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         FLASH: begin
            if (step_tick) begin
               bright_d = (bright_q == BRIGHT_FULL) ? DIM : BRIGHT_FULL;
               tog_d    = tog_q + 1'b1;
               if (tog_q == TOG_LAST) begin
                  state_d  = IDLE;
                  bright_d = BRIGHT_FULL;
                  done_d   = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   bg_color_scale u_scale_r (.color(red_in),   .bright(bright_q), .scaled(red_s));
   bg_color_scale u_scale_g (.color(green_in), .bright(bright_q), .scaled(green_s));
   bg_color_scale u_scale_b (.color(blue_in),  .bright(bright_q), .scaled(blue_s));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_valid_out <= 1'b0;
         red_out       <= '0;
         green_out     <= '0;
         blue_out      <= '0;
      end else begin
         pix_valid_out <= pix_valid_in;
         red_out       <= pix_valid_in ? red_s   : '0;
         green_out     <= pix_valid_in ? green_s : '0;
         blue_out      <= pix_valid_in ? blue_s  : '0;
      end
   end

endmodule

// File: tb/tb_background_fade_ctrl.sv
// Directed bench: three fader instances with FRAMES_PER_STEP of 1, 2 and 4.
module tb_background_fade_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       frame_start = 1'b0;
   logic [2:0] cv = '0;
   logic [1:0] cmd_op = '0;
   logic       pix_valid_in = 1'b0;
   logic [3:0] red_in = '0, green_in = '0, blue_in = '0;

   logic       cmd_ready [3];
   logic       pvo [3];
   logic [3:0] ro [3];
   logic [3:0] go [3];
   logic [3:0] bo [3];
   logic [4:0] bri [3];
   logic       busy [3];
   logic       done [3];

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      background_fade_ctrl #(
         .FRAMES_PER_STEP((g == 0) ? 1 : ((g == 1) ? 2 : 4)),
         .FLASH_TOGGLES(8),
         .FLASH_DIM(8)
      ) u_dut (
         .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
         .cmd_valid(cv[g]), .cmd_ready(cmd_ready[g]), .cmd_op(cmd_op),
         .pix_valid_in(pix_valid_in), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
         .pix_valid_out(pvo[g]), .red_out(ro[g]), .green_out(go[g]), .blue_out(bo[g]),
         .brightness(bri[g]), .busy(busy[g]), .done(done[g])
      );
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      step();
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (bri[i] !== 5'd16) begin bad++; $display("FAIL reset_bright[%0d] got=%0d exp=16", i, bri[i]); end
         total++;
         if (cmd_ready[i] !== 1'b1 || busy[i] !== 1'b0 || done[i] !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl[%0d] got rdy=%b busy=%b done=%b exp 1,0,0", i, cmd_ready[i], busy[i], done[i]);
         end
         total++;
         if (pvo[i] !== 1'b0 || {ro[i], go[i], bo[i]} !== 12'h000) begin
            bad++; $display("FAIL reset_pix[%0d] got v=%b rgb=%h exp 0,000", i, pvo[i], {ro[i], go[i], bo[i]});
         end
      end
      step();
      step();
      rst_n = 1'b1;
      step();
      red_in = 4'hF; green_in = 4'h8; blue_in = 4'h4; pix_valid_in = 1'b1;
      step();
      pix_valid_in = 1'b0;
      total++;
      if (pvo[0] !== 1'b1 || {ro[0], go[0], bo[0]} !== 12'hF84) begin
         bad++; $display("FAIL idle_pix got v=%b rgb=%h exp 1,F84", pvo[0], {ro[0], go[0], bo[0]});
      end
   endtask

   task automatic test_scaling();
      cv[0] = 1'b1; cmd_op = 2'd0;
      step();
      cv[0] = 1'b0;
      total++;
      if (busy[0] !== 1'b1 || bri[0] !== 5'd16) begin bad++; $display("FAIL fo1_accept got busy=%b bri=%0d exp 1,16", busy[0], bri[0]); end
      for (int i = 0; i < 8; i++) frame();
      total++;
      if (bri[0] !== 5'd8) begin bad++; $display("FAIL fo1_bright8 got=%0d exp=8", bri[0]); end
      // Pixel coinciding with a step: uses brightness 8, not the new 7.
      red_in = 4'hF; green_in = 4'h8; blue_in = 4'h4; pix_valid_in = 1'b1; frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      total++;
      if (pvo[0] !== 1'b1 || {ro[0], go[0], bo[0]} !== 12'h742) begin
         bad++; $display("FAIL scale8 got v=%b rgb=%h exp 1,742", pvo[0], {ro[0], go[0], bo[0]});
      end
      total++;
      if (bri[0] !== 5'd7) begin bad++; $display("FAIL fo1_bright7 got=%0d exp=7", bri[0]); end
      red_in = 4'hF; green_in = 4'hF; blue_in = 4'hF;
      step();
      total++;
      if ({ro[0], go[0], bo[0]} !== 12'h666) begin bad++; $display("FAIL scale7 got rgb=%h exp 666", {ro[0], go[0], bo[0]}); end
      pix_valid_in = 1'b0;
      step();
      total++;
      if (pvo[0] !== 1'b0 || {ro[0], go[0], bo[0]} !== 12'h000) begin
         bad++; $display("FAIL blank got v=%b rgb=%h exp 0,000", pvo[0], {ro[0], go[0], bo[0]});
      end
      for (int i = 0; i < 6; i++) frame();
      total++;
      if (bri[0] !== 5'd1 || done[0] !== 1'b0) begin bad++; $display("FAIL fo1_bright1 got bri=%0d done=%b exp 1,0", bri[0], done[0]); end
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      total++;
      if (bri[0] !== 5'd0 || done[0] !== 1'b1 || busy[0] !== 1'b0) begin
         bad++; $display("FAIL fo1_end got bri=%0d done=%b busy=%b exp 0,1,0", bri[0], done[0], busy[0]);
      end
      step();
      total++;
      if (done[0] !== 1'b0) begin bad++; $display("FAIL fo1_done_once got=%b exp=0", done[0]); end
   endtask

   task automatic test_coincident();
      cv[0] = 1'b1; cmd_op = 2'd1; frame_start = 1'b1;
      step();
      cv[0] = 1'b0; frame_start = 1'b0;
      total++;
      if (bri[0] !== 5'd0 || busy[0] !== 1'b1) begin bad++; $display("FAIL fi_coinc got bri=%0d busy=%b exp 0,1", bri[0], busy[0]); end
      step();
      total++;
      if (bri[0] !== 5'd0) begin bad++; $display("FAIL fi_hold got=%0d exp=0", bri[0]); end
      frame();
      total++;
      if (bri[0] !== 5'd1) begin bad++; $display("FAIL fi_first got=%0d exp=1", bri[0]); end
      for (int i = 0; i < 4; i++) frame();
      total++;
      if (bri[0] !== 5'd5) begin bad++; $display("FAIL fi_bright5 got=%0d exp=5", bri[0]); end
   endtask

   task automatic test_reset_mid();
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (bri[0] !== 5'd16 || busy[0] !== 1'b0 || cmd_ready[0] !== 1'b1 || done[0] !== 1'b0) begin
         bad++; $display("FAIL midreset got bri=%0d busy=%b rdy=%b done=%b exp 16,0,1,0", bri[0], busy[0], cmd_ready[0], done[0]);
      end
      #2 rst_n = 1'b1;
      step();
      step();
      total++;
      if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin bad++; $display("FAIL midreset_after got done=%b busy=%b exp 0,0", done[0], busy[0]); end
      cv[0] = 1'b1; cmd_op = 2'd3;
      step();
      cv[0] = 1'b0;
      total++;
      if (done[0] !== 1'b1 || busy[0] !== 1'b0 || bri[0] !== 5'd16) begin
         bad++; $display("FAIL snap got done=%b busy=%b bri=%0d exp 1,0,16", done[0], busy[0], bri[0]);
      end
      step();
      total++;
      if (done[0] !== 1'b0) begin bad++; $display("FAIL snap_once got=%b exp=0", done[0]); end
   endtask

   task automatic test_fade_out4();
      int exp_b;
      cv[2] = 1'b1; cmd_op = 2'd0;
      step();
      cv[2] = 1'b0;
      for (int f = 1; f <= 64; f++) begin
         frame_start = 1'b1;
         step();
         frame_start = 1'b0;
         exp_b = 16 - f / 4;
         total++;
         if (bri[2] !== 5'(exp_b) || done[2] !== (f == 64) || busy[2] !== (f < 64) || cmd_ready[2] !== (f == 64)) begin
            bad++;
            $display("FAIL fo4 frame %0d got bri=%0d done=%b busy=%b rdy=%b exp %0d,%b,%b,%b",
                     f, bri[2], done[2], busy[2], cmd_ready[2], exp_b, f == 64, f < 64, f == 64);
         end
         if (f == 20) begin cv[2] = 1'b1; cmd_op = 2'd1; end
         step();
         cv[2] = 1'b0;
         total++;
         if (done[2] !== 1'b0) begin bad++; $display("FAIL fo4_gap frame %0d got done=%b exp=0", f, done[2]); end
      end
      frame();
      total++;
      if (bri[2] !== 5'd0 || busy[2] !== 1'b0) begin bad++; $display("FAIL fo4_idle got bri=%0d busy=%b exp 0,0", bri[2], busy[2]); end
      cv[2] = 1'b1; cmd_op = 2'd3;
      step();
      cv[2] = 1'b0;
      total++;
      if (bri[2] !== 5'd16 || done[2] !== 1'b1) begin bad++; $display("FAIL snap_low got bri=%0d done=%b exp 16,1", bri[2], done[2]); end
   endtask

   task automatic test_flash();
      int exp_b;
      cv[1] = 1'b1; cmd_op = 2'd2;
      step();
      cv[1] = 1'b0;
      total++;
      if (busy[1] !== 1'b1 || bri[1] !== 5'd16) begin bad++; $display("FAIL flash_accept got busy=%b bri=%0d exp 1,16", busy[1], bri[1]); end
      for (int f = 1; f <= 16; f++) begin
         frame_start = 1'b1;
         step();
         frame_start = 1'b0;
         exp_b = ((f / 2) % 2 == 1) ? 8 : 16;
         total++;
         if (bri[1] !== 5'(exp_b) || done[1] !== (f == 16) || busy[1] !== (f < 16)) begin
            bad++;
            $display("FAIL flash frame %0d got bri=%0d done=%b busy=%b exp %0d,%b,%b",
                     f, bri[1], done[1], busy[1], exp_b, f == 16, f < 16);
         end
         step();
      end
      total++;
      if (done[1] !== 1'b0 || cmd_ready[1] !== 1'b1) begin bad++; $display("FAIL flash_end got done=%b rdy=%b exp 0,1", done[1], cmd_ready[1]); end
   endtask

   initial begin
      test_reset();
      test_scaling();
      test_coincident();
      test_reset_mid();
      test_fade_out4();
      test_flash();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/background_fade_ctrl.md
Name: background_fade_ctrl

Overview:
- Frame-synchronous brightness sequencer placed between the background palette lookup and the VGA colour outputs.
- Accepts fade-out, fade-in, flash (level-complete maze flash) and snap-to-full commands from game logic.
- Steps a brightness register only at frame boundaries, so no frame tears mid-scan.
- Scales each 4-bit RGB palette colour by the current brightness, with one registered pipeline stage.

Parameters:
FRAMES_PER_STEP, 4, frame_start pulses per brightness step or flash toggle (>=1)
FLASH_TOGGLES, 8, number of brightness toggles in a flash sequence (even, >=2)
FLASH_DIM, 8, brightness used on the dim phase of a flash (0..16)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
frame_start  in  1  single-cycle pulse at start of vertical blank
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_op  in  2  0=FADE_OUT, 1=FADE_IN, 2=FLASH, 3=SNAP_FULL
pix_valid_in  in  1  active-video pixel present
red_in/green_in/blue_in  in  4 each  palette colour
pix_valid_out  out  1  pix_valid_in delayed 1 cycle
red_out/green_out/blue_out  out  4 each  scaled colour
brightness  out  5  current brightness, 0..16 (16 = identity)
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset (async assert, sync release): state=IDLE, brightness=16, frame counter=0, toggle counter=0, all colour outputs=0, pix_valid_out=0, done=0, busy=0. cmd_ready is combinational (state==IDLE), so it reads 1 during and after reset.
- Handshake: commands are accepted only in IDLE. cmd_valid in a non-IDLE state is ignored, not queued.
- States: IDLE, FADE_OUT, FADE_IN, FLASH.
- Step tick: a step tick is every FRAMES_PER_STEP-th frame_start counted after acceptance. The frame counter resets to 0 on acceptance and increments only on frame_start.
- Acceptance coinciding with frame_start: that frame_start does not count.
- FADE_OUT: on each step tick, brightness decrements by 1. When brightness reaches 0, go to IDLE and pulse done in the cycle after that update.
  - If brightness is already 0 at acceptance: stay in FADE_OUT until the first step tick, then go to IDLE and pulse done with no change.
- FADE_IN: symmetric to FADE_OUT, incrementing to 16.
- FLASH:
  - On acceptance, brightness is set to 16.
  - On each step tick, brightness toggles 16<->FLASH_DIM and the toggle counter increments.
  - After FLASH_TOGGLES toggles, brightness is 16; go to IDLE and pulse done.
- SNAP_FULL: accepted at cycle k; brightness=16 and done=1 at k+1. No busy cycle; state stays IDLE.
- Pixel path:
  - Each channel: out = (in * brightness) >> 4, using an 8-bit product, so the result never exceeds 15.
  - Registered: inputs at cycle k appear at k+1, scaled by the brightness register value at cycle k.
  - pix_valid_in=0 forces the registered colour to 0 (blanking).
- A brightness change in the same cycle as a pixel affects pixels from the next cycle only.
- Reset mid-operation: returns immediately to reset values; no done pulse is issued.

Decomposition:
- Package bg_fade_pkg holds:
  - state enum fade_state_t {IDLE, FADE_OUT, FADE_IN, FLASH};
  - op enum fade_op_t;
  - constants BRIGHT_W=5, BRIGHT_FULL=16, COLOR_W=4.
- Sub-module bg_color_scale: purely combinational, one 4-bit channel x 5-bit brightness -> 4-bit result. Three instances; the pipeline register lives in the parent.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> all outputs 0, brightness=16, cmd_ready=1 asynchronously. Pixel F,8,4 with valid -> F,8,4 one cycle later.
- Scaling: force brightness=8 via FADE_OUT with FRAMES_PER_STEP=1 after 8 frame_starts. Input F,8,4 -> output 7,4,2; pix_valid_in=0 -> output 0,0,0.
- FADE_OUT, FRAMES_PER_STEP=4: brightness steps 16->0 on every 4th frame_start, done pulses once after the 64th frame_start, busy high throughout. A second cmd_valid mid-fade is ignored.
- FLASH, FLASH_TOGGLES=8, FLASH_DIM=8, FRAMES_PER_STEP=2: brightness sequence 16,8,16,... across 8 toggles, ends at 16, done once.
- Command and frame_start in the same cycle: FADE_IN from 0 with FRAMES_PER_STEP=1 -> first increment at the next frame_start, not the coincident one.
- Reset mid-FADE_IN at brightness 5: brightness=16, state IDLE, no done pulse; SNAP_FULL afterwards -> done at k+1.
